// File: rtl/bsg_manycore_trace_injector_pkg.sv
// rtl/bsg_manycore_trace_injector_pkg.sv - shared types, op encodings and FSM states for the trace injector
//
// Provides:
//   `BSG_DECLARE_MANYCORE_PACKET_S        forward packet struct (bsg_manycore_packet_s)
//   `BSG_DECLARE_MANYCORE_RETURN_PACKET_S return packet struct (bsg_manycore_return_packet_s)
//   `BSG_DECLARE_MANYCORE_TRACE_ENTRY_S   trace entry struct (bsg_manycore_trace_entry_s)
//   package bsg_manycore_trace_injector_pkg: op encodings, FSM state codes, width helpers
`ifndef BSG_MANYCORE_TRACE_INJECTOR_PKG_MACROS
`define BSG_MANYCORE_TRACE_INJECTOR_PKG_MACROS

`define BSG_DECLARE_MANYCORE_PACKET_S(addr_w, data_w, x_w, y_w, lid_w) \
  typedef struct packed { \
    logic [1:0]              op; \
    logic [(data_w)/8-1:0]   op_ex; \
    logic [(addr_w)-1:0]     addr; \
    logic [(data_w)-1:0]     payload; \
    logic [(lid_w)-1:0]      load_id; \
    logic [(y_w)-1:0]        src_y_cord; \
    logic [(x_w)-1:0]        src_x_cord; \
    logic [(y_w)-1:0]        y_cord; \
    logic [(x_w)-1:0]        x_cord; \
  } bsg_manycore_packet_s

`define BSG_DECLARE_MANYCORE_RETURN_PACKET_S(data_w, x_w, y_w, lid_w) \
  typedef struct packed { \
    logic [1:0]              pkt_type; \
    logic [(data_w)-1:0]     data; \
    logic [(lid_w)-1:0]      load_id; \
    logic [(y_w)-1:0]        y_cord; \
    logic [(x_w)-1:0]        x_cord; \
  } bsg_manycore_return_packet_s

`define BSG_DECLARE_MANYCORE_TRACE_ENTRY_S(addr_w, data_w, x_w, y_w) \
  typedef struct packed { \
    logic                    last; \
    logic [1:0]              op; \
    logic [(data_w)/8-1:0]   op_ex; \
    logic [(addr_w)-1:0]     addr; \
    logic [(data_w)-1:0]     data; \
    logic [(y_w)-1:0]        y_cord; \
    logic [(x_w)-1:0]        x_cord; \
  } bsg_manycore_trace_entry_s

`endif

package bsg_manycore_trace_injector_pkg;

  typedef enum logic [1:0] {
    e_op_load   = 2'd0,
    e_op_store  = 2'd1,
    e_op_remote = 2'd2
  } bsg_manycore_op_e;

  localparam logic [2:0] s_idle  = 3'd0;
  localparam logic [2:0] s_fetch = 3'd1;
  localparam logic [2:0] s_send  = 3'd2;
  localparam logic [2:0] s_drain = 3'd3;
  localparam logic [2:0] s_done  = 3'd4;

  function automatic int packet_width(input int addr_w, input int data_w, input int x_w,
                                      input int y_w, input int lid_w);
    return 2 + data_w / 8 + addr_w + data_w + lid_w + 2 * (x_w + y_w);
  endfunction

  function automatic int return_packet_width(input int data_w, input int x_w, input int y_w,
                                             input int lid_w);
    return 2 + data_w + lid_w + x_w + y_w;
  endfunction

  function automatic int trace_entry_width(input int addr_w, input int data_w, input int x_w,
                                           input int y_w);
    return 3 + data_w / 8 + addr_w + data_w + x_w + y_w;
  endfunction

endpackage

// File: rtl/bsg_manycore_credit_counter.sv
// rtl/bsg_manycore_credit_counter.sv - saturating up/down credit counter for link initiators
//
// Ports:
//   clk_i, reset_n_i  clock, asynchronous active-low reset (count resets to max_val_p)
//   up_i              credit returned
//   down_i            credit consumed
//   count_o           credits currently available
module bsg_manycore_credit_counter #(
  parameter int max_val_p = 16,
  parameter int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o
);

  localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);

  logic [width_lp-1:0] count_r;

  // Simultaneous up and down cancel; either direction clamps at its limit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= max_lp;
    end else if (up_i && !down_i) begin
      if (count_r != max_lp) count_r <= count_r + width_lp'(1);
    end else if (down_i && !up_i) begin
      if (count_r != '0) count_r <= count_r - width_lp'(1);
    end
  end

  assign count_o = count_r;

  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(up_i && !down_i && count_r == max_lp));
      assert (!(down_i && !up_i && count_r == '0));
    end
  end

endmodule

// File: rtl/bsg_manycore_trace_injector.sv
// rtl/bsg_manycore_trace_injector.sv - trace-driven manycore link initiator with credit tracking
//
// Optional logging: define BSG_MANYCORE_TRACE_INJECTOR_LOG_EN.
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   my_x_i, my_y_i            own coordinates, placed in the packet's return address
//   trace_v_i/trace_entry_i   incoming trace entries, accepted with trace_ready_o
//   pkt_v_o/pkt_data_o        forward packet, handshaken with pkt_ready_i
//   ret_v_i/ret_data_i        return packets, ret_ready_o high once out of reset
//   credits_o                 outstanding-request credits available
//   done_o                    last entry issued and all credits returned
module bsg_manycore_trace_injector
  import bsg_manycore_trace_injector_pkg::*;
#(
  parameter int addr_width_p           = 28,
  parameter int data_width_p           = 32,
  parameter int x_cord_width_p         = 4,
  parameter int y_cord_width_p         = 4,
  parameter int load_id_width_p        = 5,
  parameter int max_out_credits_p      = 16,
  parameter int packet_width_lp        = packet_width(addr_width_p, data_width_p, x_cord_width_p,
                                                      y_cord_width_p, load_id_width_p),
  parameter int return_packet_width_lp = return_packet_width(data_width_p, x_cord_width_p,
                                                             y_cord_width_p, load_id_width_p),
  parameter int trace_entry_width_lp   = trace_entry_width(addr_width_p, data_width_p,
                                                           x_cord_width_p, y_cord_width_p),
  parameter int credit_width_lp        = $clog2(max_out_credits_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [x_cord_width_p-1:0]         my_x_i,
  input  logic [y_cord_width_p-1:0]         my_y_i,
  input  logic                              trace_v_i,
  input  logic [trace_entry_width_lp-1:0]   trace_entry_i,
  output logic                              trace_ready_o,
  output logic                              pkt_v_o,
  output logic [packet_width_lp-1:0]        pkt_data_o,
  input  logic                              pkt_ready_i,
  input  logic                              ret_v_i,
  input  logic [return_packet_width_lp-1:0] ret_data_i,
  output logic                              ret_ready_o,
  output logic [credit_width_lp-1:0]        credits_o,
  output logic                              done_o
);

  `BSG_DECLARE_MANYCORE_PACKET_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p, load_id_width_p);
  `BSG_DECLARE_MANYCORE_TRACE_ENTRY_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);

  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  bsg_manycore_trace_entry_s entry;
  bsg_manycore_packet_s      pkt_r, pkt_n;
  logic [2:0]                state_r;
  logic                      last_r;
  logic [load_id_width_p-1:0] load_id_r;
  logic [credit_width_lp-1:0] credits;
  logic                      accept, send;

  assign entry = bsg_manycore_trace_entry_s'(trace_entry_i);

  assign trace_ready_o = (state_r == s_fetch) && (credits != '0);
  assign accept        = trace_v_i && trace_ready_o;
  assign pkt_v_o       = (state_r == s_send);
  assign send          = pkt_v_o && pkt_ready_i;
  assign ret_ready_o   = (state_r != s_idle);
  assign done_o        = (state_r == s_done);
  assign pkt_data_o    = pkt_r;
  assign credits_o     = credits;

  // Only loads consume a load id; other ops carry zero in that field.
  always_comb begin
    pkt_n            = '0;
    pkt_n.op         = entry.op;
    pkt_n.op_ex      = entry.op_ex;
    pkt_n.addr       = entry.addr;
    pkt_n.payload    = entry.data;
    pkt_n.load_id    = (entry.op == e_op_load) ? load_id_r : '0;
    pkt_n.src_y_cord = my_y_i;
    pkt_n.src_x_cord = my_x_i;
    pkt_n.y_cord     = entry.y_cord;
    pkt_n.x_cord     = entry.x_cord;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= s_idle;
      pkt_r     <= '0;
      last_r    <= 1'b0;
      load_id_r <= '0;
    end else begin
      case (state_r)
        s_idle: state_r <= s_fetch;
        s_fetch: begin
          if (accept) begin
            pkt_r   <= pkt_n;
            last_r  <= entry.last;
            if (entry.op == e_op_load) load_id_r <= load_id_r + load_id_width_p'(1);
            state_r <= s_send;
          end
        end
        s_send: begin
          if (pkt_ready_i) state_r <= last_r ? s_drain : s_fetch;
        end
        s_drain: begin
          if (credits == max_credits_lp) state_r <= s_done;
        end
        s_done:  state_r <= s_done;
        default: state_r <= s_idle;
      endcase
    end
  end

  bsg_manycore_credit_counter #(
    .max_val_p(max_out_credits_p),
    .width_lp (credit_width_lp)
  ) credit_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .up_i     (ret_v_i),
    .down_i   (send),
    .count_o  (credits)
  );

  // Return contents matter only to the optional log.
  logic unused_ret_data;
  assign unused_ret_data = ^ret_data_i;

  // A stalled packet must stay valid with identical contents until taken.
  logic                 hold_q;
  bsg_manycore_packet_s hold_pkt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) hold_q <= 1'b0;
    else            hold_q <= pkt_v_o && !pkt_ready_i;
  end

  always_ff @(posedge clk_i) begin
    hold_pkt_q <= pkt_r;
  end

  always @(posedge clk_i) begin
    if (reset_n_i && hold_q) begin
      assert (pkt_v_o && (pkt_r == hold_pkt_q));
    end
  end

`ifdef BSG_MANYCORE_TRACE_INJECTOR_LOG_EN
  `BSG_DECLARE_MANYCORE_RETURN_PACKET_S(data_width_p, x_cord_width_p, y_cord_width_p, load_id_width_p);
  bsg_manycore_return_packet_s ret_pkt;
  int unsigned log_sent, log_cycles;
  logic        log_done_printed;

  assign ret_pkt = bsg_manycore_return_packet_s'(ret_data_i);

  always @(negedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      log_sent         <= 0;
      log_cycles       <= 0;
      log_done_printed <= 1'b0;
    end else begin
      log_cycles <= log_cycles + 1;
      if (send) begin
        log_sent <= log_sent + 1;
        $display("->{%0d,%0h %0h,%0h,YX={%0d,%0d->%0d,%0d}}",
                 pkt_r.op, pkt_r.op_ex, pkt_r.addr, pkt_r.payload,
                 pkt_r.src_y_cord, pkt_r.src_x_cord, pkt_r.y_cord, pkt_r.x_cord);
      end
      if (ret_v_i) begin
        $display("<-c(YX=%0d,%0d) credits=%0d",
                 ret_pkt.y_cord, ret_pkt.x_cord, credits);
      end
      if (done_o && !log_done_printed) begin
        log_done_printed <= 1'b1;
        $display("done: sent=%0d cycles=%0d", log_sent, log_cycles);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_manycore_trace_injector.sv
// tb/tb_bsg_manycore_trace_injector.sv - self-checking bench for bsg_manycore_trace_injector
module tb_bsg_manycore_trace_injector;

  localparam int MAXC = 16;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [3:0]  my_x_i = 4'd3;
  logic [3:0]  my_y_i = 4'd5;
  logic        trace_v_i = 1'b0;
  logic [74:0] trace_entry_i = '0;
  logic        trace_ready_o;
  logic        pkt_v_o;
  logic [86:0] pkt_data_o;
  logic        pkt_ready_i = 1'b0;
  logic        ret_v_i = 1'b0;
  logic [46:0] ret_data_i = '0;
  logic        ret_ready_o;
  logic [4:0]  credits_o;
  logic        done_o;

  always #5 clk_i = ~clk_i;

  bsg_manycore_trace_injector dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .my_x_i       (my_x_i),
    .my_y_i       (my_y_i),
    .trace_v_i    (trace_v_i),
    .trace_entry_i(trace_entry_i),
    .trace_ready_o(trace_ready_o),
    .pkt_v_o      (pkt_v_o),
    .pkt_data_o   (pkt_data_o),
    .pkt_ready_i  (pkt_ready_i),
    .ret_v_i      (ret_v_i),
    .ret_data_i   (ret_data_i),
    .ret_ready_o  (ret_ready_o),
    .credits_o    (credits_o),
    .done_o       (done_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: expected packets in order, event counts, phase flags.
  logic [86:0] exp_q[$];
  bit          last_q[$];
  logic [74:0] feed_q[$];
  logic [4:0]  lid_log[$];
  int n_sent = 0, n_ret = 0, n_loads = 0, cred_m;
  int accepted_cnt = 0, popped_cnt = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  int ret_mode = 0;     // 0: driven by the test sequence, 1: random returns
  bit drain_m = 0, done_m = 0, idle_m = 1;

  function automatic logic [74:0] mk_entry(input logic last, input logic [1:0] op,
      input logic [3:0] op_ex, input logic [27:0] addr, input logic [31:0] data,
      input logic [3:0] y, input logic [3:0] x);
    return {last, op, op_ex, addr, data, y, x};
  endfunction

  function automatic logic [74:0] rnd_entry(input logic last, input logic [1:0] op);
    return mk_entry(last, op, 4'($urandom), 28'($urandom), 32'($urandom),
                    4'($urandom), 4'($urandom));
  endfunction

  function automatic logic [86:0] exp_pkt(input logic [74:0] e, input logic [4:0] lid);
    logic [1:0] op;
    op = e[73:72];
    return {op, e[71:68], e[67:40], e[39:8], (op == 2'd0) ? lid : 5'd0,
            my_y_i, my_x_i, e[7:4], e[3:0]};
  endfunction

  // Compare process: outputs are checked every cycle at the falling edge,
  // then the events that commit at the next rising edge update the model.
  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      n_sent = 0; n_ret = 0; n_loads = 0;
      exp_q.delete(); last_q.delete();
      drain_m = 0; done_m = 0; idle_m = 1;
    end else begin
      cred_m = MAXC - n_sent + n_ret;
      chk("credits", credits_o, cred_m);
      chk("pkt_v", pkt_v_o, exp_q.size() > 0);
      chk("trace_ready", trace_ready_o,
          !idle_m && exp_q.size() == 0 && !drain_m && !done_m && cred_m > 0);
      chk("ret_ready", ret_ready_o, !idle_m);
      chk("done", done_o, done_m);
      if (drain_m && cred_m == MAXC) done_m = 1;
      if (pkt_v_o && pkt_ready_i && exp_q.size() > 0) begin
        chk("pkt_data", pkt_data_o, exp_q[0]);
        if (pkt_data_o[86:85] == 2'd0) lid_log.push_back(pkt_data_o[20:16]);
        if (last_q[0]) drain_m = 1;
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
        n_sent++;
      end
      if (ret_v_i) n_ret++;
      if (trace_v_i && trace_ready_o) begin
        exp_q.push_back(exp_pkt(trace_entry_i, 5'(n_loads % 32)));
        last_q.push_back(trace_entry_i[74]);
        if (trace_entry_i[73:72] == 2'd0) n_loads++;
        accepted_cnt++;
      end
      idle_m = 0;
    end
  end

  // Input driver: trace feed, network readiness, random returns.
  always @(posedge clk_i) begin
    #1;
    if (accepted_cnt > popped_cnt) begin
      void'(feed_q.pop_front());
      popped_cnt++;
    end
    if (feed_q.size() > 0) begin
      trace_v_i = 1'b1;
      trace_entry_i = feed_q[0];
    end else begin
      trace_v_i = 1'b0;
    end
    case (ready_mode)
      0:       pkt_ready_i = 1'b1;
      1:       pkt_ready_i = 1'($urandom_range(0, 1));
      default: pkt_ready_i = 1'b0;
    endcase
    if (ret_mode == 1) begin
      ret_v_i = (n_sent - n_ret > 0) && ($urandom_range(0, 2) != 0);
      ret_data_i = 47'({$urandom, $urandom});
    end
  end

  task automatic do_reset();
    @(posedge clk_i); #2;
    reset_n_i = 1'b0;
    ret_mode = 0; ready_mode = 0; ret_v_i = 1'b0;
    feed_q.delete();
    popped_cnt = accepted_cnt;
    #1;
    chk("rst_pkt_v", pkt_v_o, 1'b0);
    chk("rst_trace_ready", trace_ready_o, 1'b0);
    chk("rst_ret_ready", ret_ready_o, 1'b0);
    chk("rst_credits", credits_o, 5'd16);
    chk("rst_done", done_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #2 reset_n_i = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done_o && k < budget) begin
      @(posedge clk_i); #2;
      k++;
    end
    chk("done_reached", done_o, 1'b1);
  endtask

  task automatic wait_pkt_v(input int budget);
    int k;
    k = 0;
    while (!pkt_v_o && k < budget) begin
      @(posedge clk_i); #2;
      k++;
    end
    chk("pkt_v_reached", pkt_v_o, 1'b1);
  endtask

  initial begin
    logic [86:0] held;
    int k;

    do_reset();

    // Single store, return three cycles after issue.
    feed_q.push_back(mk_entry(1'b1, 2'd1, 4'hF, 28'h100, 32'hDEADBEEF, 4'd2, 4'd1));
    wait_pkt_v(10);
    chk("store_literal", pkt_data_o,
        {2'd1, 4'hF, 28'h100, 32'hDEADBEEF, 5'd0, 4'd5, 4'd3, 4'd2, 4'd1});
    @(posedge clk_i); #2;
    chk("store_credits15", credits_o, 5'd15);
    repeat (2) @(posedge clk_i);
    #2 ret_v_i = 1'b1;
    @(posedge clk_i); #2;
    ret_v_i = 1'b0;
    chk("store_credits16", credits_o, 5'd16);
    chk("store_not_done_yet", done_o, 1'b0);
    @(posedge clk_i); #2;
    chk("store_done", done_o, 1'b1);

    // Twenty stores without returns stall at zero credits.
    do_reset();
    for (int i = 0; i < 20; i++) feed_q.push_back(rnd_entry(i == 19, 2'd1));
    repeat (80) @(posedge clk_i);
    #2;
    chk("stall_sent", n_sent, 16);
    chk("stall_ready", trace_ready_o, 1'b0);
    chk("stall_credits", credits_o, 5'd0);
    ret_v_i = 1'b1;
    @(posedge clk_i); #2;
    ret_v_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #2;
    chk("one_more_sent", n_sent, 17);
    ret_mode = 1;
    wait_done(400);
    chk("stall_total_sent", n_sent, 20);

    // Back-pressure holds the packet.
    do_reset();
    ready_mode = 2;
    feed_q.push_back(rnd_entry(1'b1, 2'd2));
    wait_pkt_v(10);
    held = pkt_data_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #2;
      chk("hold_v", pkt_v_o, 1'b1);
      chk("hold_data", pkt_data_o, held);
      chk("hold_credits", credits_o, 5'd16);
    end
    ready_mode = 0;
    ret_mode = 1;
    wait_done(200);

    // Forty loads: wrapping ids, done after every return.
    do_reset();
    lid_log.delete();
    ready_mode = 1;
    ret_mode = 1;
    for (int i = 0; i < 40; i++) feed_q.push_back(rnd_entry(i == 39, 2'd0));
    wait_done(2000);
    chk("loads_returns", n_ret, 40);
    chk("loads_count", lid_log.size(), 40);
    chk("lid_31", lid_log[31], 5'd31);
    chk("lid_32", lid_log[32], 5'd0);
    chk("lid_39", lid_log[39], 5'd7);

    // Send and return in the same cycle at eight credits.
    do_reset();
    for (int i = 0; i < 9; i++) feed_q.push_back(rnd_entry(i == 8, 2'd1));
    k = 0;
    while (!(pkt_v_o && credits_o == 5'd8) && k < 200) begin
      @(posedge clk_i); #2;
      k++;
    end
    chk("at8_reached", credits_o, 5'd8);
    ret_v_i = 1'b1;
    @(posedge clk_i); #2;
    ret_v_i = 1'b0;
    chk("same_cycle_credits", credits_o, 5'd8);
    chk("same_cycle_sent", n_sent, 9);
    repeat (2) @(posedge clk_i);
    #2;
    chk("drain_not_done", done_o, 1'b0);

    // Reset while draining; do_reset checks outputs immediately.
    do_reset();

    // Mixed random traffic.
    ready_mode = 1;
    ret_mode = 1;
    for (int i = 0; i < 30; i++) feed_q.push_back(rnd_entry(i == 29, 2'($urandom_range(0, 2))));
    wait_done(3000);
    chk("mixed_sent", n_sent, 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bsg_manycore_trace_injector.md
Name: bsg_manycore_trace_injector

Overview:
- Initiator-side test driver for a tile's manycore link: consumes a stream of trace entries, formats each into a bsg_manycore_packet_s, and drives it onto the forward network.
- Consumes return packets on the reverse network and tracks outstanding requests with a credit counter.
- Signals completion once the last entry has been issued and every credit has been returned.
- Sits in the testbench in place of a processor tile, so the passive link monitor can observe real traffic.

Parameters:
- addr_width_p, 28: packet address width (word address).
- data_width_p, 32: payload width.
- x_cord_width_p, 4: X coordinate width.
- y_cord_width_p, 4: Y coordinate width.
- load_id_width_p, 5: load id width; the injector tags loads with a wrapping id.
- max_out_credits_p, 16: maximum outstanding requests. Must be >= 1.
- packet_width_lp, derived: width of bsg_manycore_packet_s.
- return_packet_width_lp, derived: width of bsg_manycore_return_packet_s.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- my_x_i  in  x_cord_width_p  source X placed in return_pkt.
- my_y_i  in  y_cord_width_p  source Y placed in return_pkt.
- trace_v_i  in  1  trace entry valid.
- trace_entry_i  in  trace_entry_width_lp  {last, op, op_ex(mask), addr, data, dst_y, dst_x}.
- trace_ready_o  out  1  entry accepted when trace_v_i & trace_ready_o.
- pkt_v_o  out  1  forward packet valid.
- pkt_data_o  out  packet_width_lp  forward packet.
- pkt_ready_i  in  1  network ready (ready_and).
- ret_v_i  in  1  return packet valid.
- ret_data_i  in  return_packet_width_lp  return packet.
- ret_ready_o  out  1  tied high after reset; returns are never back-pressured.
- credits_o  out  $clog2(max_out_credits_p+1)  credits available.
- done_o  out  1  completion flag.

Behaviour:
- Reset (async assert, sync-release use): state=IDLE, pkt_v_o=0, trace_ready_o=0, ret_ready_o=0, credits_o=max_out_credits_p, done_o=0, load id=0.
- FSM states and transitions:
  - IDLE -> FETCH on the first cycle after reset.
  - FETCH: trace_ready_o=1 iff credits_o>0. On accept, register the packet; next state SEND.
  - SEND: pkt_v_o=1, pkt_data_o held stable. On pkt_ready_i: credits decrement. Next state is DRAIN if the entry had last=1, otherwise FETCH.
  - DRAIN: waits until credits_o==max_out_credits_p, then DONE.
  - DONE: done_o=1, sticky until reset; trace_ready_o=0.
- Packet formation:
  - op, op_ex, addr, data, x_cord, y_cord come from the entry.
  - return_pkt = {my_y_i, my_x_i}.
  - Loads carry the current load id, which then increments mod 2^load_id_width_p.
- Credit accounting:
  - Returning packets increment credits on ret_v_i.
  - A send and a return in the same cycle leave the count unchanged.
- Boundaries:
  - Credits are never issued below 0: FETCH stalls at 0.
  - A return while credits==max is an error: assertion fires, count saturates.
  - Entry acceptance and packet issue never overlap, so throughput is at most 1 packet per 2 cycles.
  - Reset mid-SEND drops the packet immediately (pkt_v_o=0 asynchronously).
  - pkt_v_o must not drop without handshake; assertion checks data stability while pkt_v_o & ~pkt_ready_i.

Optional Feature:
- Macro: BSG_MANYCORE_TRACE_INJECTOR_LOG_EN.
- Defined: on each negedge with a send handshake, $fwrite "->{op,op_ex addr,data,YX={sy,sx->dy,dx}}". On each return, $fwrite "<-c(YX=y,x) credits=N". At DONE, print the total sent and total cycles once.
- Undefined: no simulation output; RTL is otherwise identical.

Decomposition:
- Shared package bsg_manycore_trace_injector_pkg:
  - trace entry struct macro.
  - FSM state enum.
  - op encodings: store, load, remote-op, as already used by packet macros.
- Packet and return structs: existing `declare_bsg_manycore_packet_s macros.
- Sub-module bsg_manycore_credit_counter: up/down counter with saturation and assertions, reusable by other initiators.

Test Plan:
- Single store {last=1, addr=0x100, data=0xDEADBEEF, dst=(1,2)}, pkt_ready_i=1, return after 3 cycles -> one packet, credits 16->15->16, done_o=1 on the cycle after the return.
- 20 stores, no returns, max_out_credits_p=16 -> exactly 16 packets issued, trace_ready_o=0, credits_o=0. One return -> exactly one more packet issued.
- pkt_ready_i low for 5 cycles during SEND -> pkt_v_o held, pkt_data_o unchanged, credits unchanged until handshake.
- 40 loads -> load ids 0..31,0..7 in order, done only after 40 returns.
- Send and return in the same cycle at credits=8 -> credits stays 8.
- reset_n_i pulsed low mid-DRAIN -> all outputs return to reset values within the same cycle, credits=16, done_o=0.
